mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per cycle on operand magnitudes.
// Latency: WIDTH+2 cycles after start is sampled (CALC x WIDTH, FIX, DONE); res_write pulses in DONE.
// No backpressure: start is accepted only in IDLE; flush/rst abort. Divide datapath built only with MULT_DIV_DIVIDE_EN.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             res_write,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // hi holds the partial product / remainder, lo the multiplier / quotient
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    // m is the multiplicand magnitude (multiply) or divisor magnitude (divide)
    logic [WIDTH-1:0]   m_q, m_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic               res_write_q, res_write_d;

`ifdef MULT_DIV_DIVIDE_EN
    logic [WIDTH-1:0]   a_q, a_d;
    logic               sa_q, sa_d;
    logic               is_div_q, is_div_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH:0]     div_shl;
    logic [WIDTH:0]     div_diff;
`endif

    logic               accept;
    logic               is_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;

    // Operand conditioning at start: magnitudes for signed ops, and op filtering when divide is absent
    always_comb begin
        is_signed = ~op[0];
        mag_a     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        mag_b     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
`ifdef MULT_DIV_DIVIDE_EN
        accept    = start;
`else
        accept    = start & ~op[1];
`endif
    end

    // Per-step datapath: shift-add for multiply, restoring trial subtract for divide, and product sign fix
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        prod_fix = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
`ifdef MULT_DIV_DIVIDE_EN
        div_shl  = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_shl - {1'b0, m_q};
`endif
    end

    // Next-state and datapath control; flush overrides everything except reset
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        m_d         = m_q;
        neg_d       = neg_q;
        res_hi_d    = res_hi_q;
        res_lo_d    = res_lo_q;
        res_write_d = 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
        a_d         = a_q;
        sa_d        = sa_q;
        is_div_d    = is_div_q;
        dbz_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    hi_d    = '0;
                    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULT_DIV_DIVIDE_EN
                    a_d      = a;
                    sa_d     = is_signed & a[WIDTH-1];
                    is_div_d = op[1];
                    if (op[1]) begin
                        lo_d = mag_a;
                        m_d  = mag_b;
                    end else begin
                        lo_d = mag_b;
                        m_d  = mag_a;
                    end
`else
                    lo_d = mag_b;
                    m_d  = mag_a;
`endif
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
`ifdef MULT_DIV_DIVIDE_EN
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        hi_d = div_diff[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_shl[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
`else
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
`endif
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d     = DONE;
                res_write_d = 1'b1;
`ifdef MULT_DIV_DIVIDE_EN
                if (is_div_q) begin
                    if (m_q == '0) begin
                        // zero divisor: all-ones quotient, dividend as remainder
                        res_lo_d = {WIDTH{1'b1}};
                        res_hi_d = a_q;
                        dbz_d    = 1'b1;
                    end else begin
                        // most-negative / -1 wraps naturally back to a
                        res_lo_d = neg_q ? (~lo_q + 1'b1) : lo_q;
                        res_hi_d = sa_q ? (~hi_q + 1'b1) : hi_q;
                    end
                end else begin
                    res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    res_lo_d = prod_fix[WIDTH-1:0];
                end
`else
                res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
                res_lo_d = prod_fix[WIDTH-1:0];
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d     = IDLE;
            res_hi_d    = res_hi_q;
            res_lo_d    = res_lo_q;
            res_write_d = 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
            dbz_d       = 1'b0;
`endif
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            m_q         <= '0;
            neg_q       <= 1'b0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
            res_write_q <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
            a_q         <= '0;
            sa_q        <= 1'b0;
            is_div_q    <= 1'b0;
            dbz_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            m_q         <= m_d;
            neg_q       <= neg_d;
            res_hi_q    <= res_hi_d;
            res_lo_q    <= res_lo_d;
            res_write_q <= res_write_d;
`ifdef MULT_DIV_DIVIDE_EN
            a_q         <= a_d;
            sa_q        <= sa_d;
            is_div_q    <= is_div_d;
            dbz_q       <= dbz_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign res_write = res_write_q;
    assign res_hi    = res_hi_q;
    assign res_lo    = res_lo_q;
`ifdef MULT_DIV_DIVIDE_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         res_write;
    logic [W-1:0] res_hi;
    logic [W-1:0] res_lo;
    logic         div_by_zero;

    int checks   = 0;
    int errors   = 0;
    int n_writes = 0;

    // scoreboard entries: {div_by_zero, res_hi, res_lo}
    logic [2*W:0] exp_q[$];
    logic [2*W:0] mon_e;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .res_write   (res_write),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    // output monitor: pops the scoreboard on every write strobe
    always @(negedge clk) begin
        if (res_write) begin
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got hi=%h lo=%h dbz=%b, required no write", res_hi, res_lo, div_by_zero);
            end else begin
                mon_e = exp_q.pop_front();
                if ({div_by_zero, res_hi, res_lo} !== mon_e) begin
                    errors++;
                    $display("FAIL result: got dbz=%b hi=%h lo=%h, required dbz=%b hi=%h lo=%h",
                             div_by_zero, res_hi, res_lo, mon_e[2*W], mon_e[2*W-1:W], mon_e[W-1:0]);
                end
            end
        end else if (div_by_zero !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL dbz_outside_done: got %b, required 0", div_by_zero);
        end
    end

    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] ex, ey, p;
        logic [2*W-1:0]        pu;
        logic signed [W-1:0]   sx, sy, q, r;
        model = '0;
        case (o)
            2'b00: begin
                ex = $signed(x);
                ey = $signed(y);
                p  = ex * ey;
                model = {1'b0, p};
            end
            2'b01: begin
                pu = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                model = {1'b0, pu};
            end
            2'b10: begin
                if (y == '0) model = {1'b1, x, {W{1'b1}}};
                else if (x == {1'b1, {(W-1){1'b0}}} && y == {W{1'b1}}) model = {1'b0, {W{1'b0}}, x};
                else begin
                    sx = x;
                    sy = y;
                    q  = sx / sy;
                    r  = sx % sy;
                    model = {1'b0, r, q};
                end
            end
            default: begin
                if (y == '0) model = {1'b1, x, {W{1'b1}}};
                else model = {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    // one complete operation: scrambles inputs after start, checks busy length and write position
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [2*W:0] e, input string name);
        int cyc, wpos, w0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        exp_q.push_back(e);
        w0 = n_writes;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        cyc = 0; wpos = 0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            cyc++;
            if (res_write) wpos = cyc;
            @(negedge clk);
        end
        checks++;
        if (cyc !== W+2 || wpos !== W+2) begin
            errors++;
            $display("FAIL %s_timing: got busy=%0d write_at=%0d, required %0d/%0d", name, cyc, wpos, W+2, W+2);
        end
        checks++;
        if (n_writes - w0 !== 1) begin
            errors++;
            $display("FAIL %s_writes: got %0d, required 1", name, n_writes - w0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, res_write, div_by_zero} !== 3'b000 || res_hi !== '0 || res_lo !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b wr=%b dbz=%b hi=%h lo=%h, required all 0",
                     busy, res_write, div_by_zero, res_hi, res_lo);
        end
        rst = 1'b0;
    endtask

    task automatic test_mult();
        logic [W-1:0] x, y;
        logic [1:0]   o;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFE, 32'h00000001}, "multu_max");
        run_op(2'b00, 32'hFFFFFFFD, 32'd7, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB}, "mult_neg");
        run_op(2'b00, 32'h80000000, 32'h80000000, {1'b0, 32'h40000000, 32'h00000000}, "mult_minmin");
        run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h00000000, 32'h80000000}, "mult_min_m1");
        run_op(2'b01, 32'h0000ABCD, 32'h00001111, {1'b0, 32'h00000000, 32'h0B74059D}, "multu_small");
        for (int i = 0; i < 6; i++) begin
            o = 2'($urandom_range(0, 1));
            x = $urandom; y = $urandom;
            run_op(o, x, y, model(o, x, y), "mult_rand");
        end
    endtask

`ifdef MULT_DIV_DIVIDE_EN
    task automatic test_divide();
        logic [W-1:0] x, y;
        logic [1:0]   o;
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD}, "div_neg");
        run_op(2'b11, 32'd100, 32'd0, {1'b1, 32'h00000064, 32'hFFFFFFFF}, "divu_zero");
        run_op(2'b10, 32'hFFFFFF9C, 32'd0, {1'b1, 32'hFFFFFF9C, 32'hFFFFFFFF}, "div_zero");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h00000000, 32'h80000000}, "div_ovf");
        run_op(2'b10, 32'd7, 32'hFFFFFFFE, {1'b0, 32'h00000001, 32'hFFFFFFFD}, "div_trunc");
        run_op(2'b11, 32'hFFFFFFFF, 32'd10, {1'b0, 32'h00000005, 32'h19999999}, "divu_big");
        for (int i = 0; i < 6; i++) begin
            o = 2'($urandom_range(2, 3));
            x = $urandom; y = $urandom >> $urandom_range(0, 28);
            run_op(o, x, y, model(o, x, y), "div_rand");
        end
    endtask
`else
    task automatic test_no_divide();
        int w0, bad;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd10; b = 32'd2;
        w0 = n_writes; bad = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0 || n_writes !== w0) begin
            errors++;
            $display("FAIL no_divide_ignored: got busy_cycles=%0d writes=%0d, required 0/0", bad, n_writes - w0);
        end
        run_op(2'b01, 32'd3, 32'd4, {1'b0, 32'd0, 32'd12}, "multu_after_div");
        checks++;
        if (res_lo !== 32'd12) begin
            errors++;
            $display("FAIL multu_after_div_lo: got %h, required %h", res_lo, 32'd12);
        end
    endtask
`endif

    task automatic test_ignored_start();
        int cyc, w0, bad;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd1000;
        exp_q.push_back({1'b0, 32'd0, 32'd1000000});
        w0 = n_writes;
        @(negedge clk);
        cyc = 0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            cyc++;
            start = (cyc == 1 || cyc == 17 || cyc == W+2);
            op = 2'b00; a = 32'd7; b = 32'd9;
            @(negedge clk);
        end
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (cyc !== W+2 || bad !== 0 || n_writes - w0 !== 1) begin
            errors++;
            $display("FAIL ignored_start: got busy=%0d late_busy=%0d writes=%0d, required %0d/0/1",
                     cyc, bad, n_writes - w0, W+2);
        end
    endtask

    task automatic test_back_to_back();
        int w0, bad, ph;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 32'd0, 32'd15});
        w0 = n_writes; bad = 0;
        for (int c = 1; c <= 3*(W+3); c++) begin
            @(negedge clk);
            ph = (c - 1) % (W+3);
            if (busy !== (ph < W+2)) bad++;
            if (res_write !== (ph == W+1)) bad++;
            if (c == 2*(W+3) + 1) start = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || n_writes - w0 !== 3) begin
            errors++;
            $display("FAIL back_to_back: got bad_cycles=%0d writes=%0d, required 0/3", bad, n_writes - w0);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, w0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        for (int i = 0; i < 20 && cyc < 10; i++) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_lo !== '0 || res_hi !== '0 || res_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b hi=%h lo=%h wr=%b, required 0/0/0/0", busy, res_hi, res_lo, res_write);
        end
        rst = 1'b0;
        w0 = n_writes;
        repeat (40) @(negedge clk);
        checks++;
        if (n_writes !== w0) begin
            errors++;
            $display("FAIL reset_mid_nowrite: got %0d writes, required 0", n_writes - w0);
        end
    endtask

    task automatic test_flush(input int at_cycle);
        int cyc, w0;
        run_op(2'b01, 32'h0000ABCD, 32'h00001111, {1'b0, 32'h00000000, 32'h0B74059D}, "pre_flush");
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        for (int i = 0; i < 60 && cyc < at_cycle; i++) begin
            @(negedge clk);
            cyc++;
        end
        flush = 1'b1;
        w0 = n_writes;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_%0d_busy: got %b, required 0", at_cycle, busy);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (n_writes !== w0 || res_hi !== 32'h0 || res_lo !== 32'h0B74059D) begin
            errors++;
            $display("FAIL flush_%0d_hold: got writes=%0d hi=%h lo=%h, required 0/00000000/0b74059d",
                     at_cycle, n_writes - w0, res_hi, res_lo);
        end
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_start: got busy=%b, required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
`ifdef MULT_DIV_DIVIDE_EN
        test_divide();
`else
        test_no_divide();
`endif
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_flush(20);
        test_flush(W+1);
        test_flush_idle();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
